midi_uart_tx: RTL and testbench



---
 rtl/midi_uart_tx.sv | 109 ++++++++++
 tb/tb_midi_uart_tx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/midi_uart_tx.sv
// MIDI OUT serializer: one byte per strobe as an 8N1 frame (start, 8 data LSB first, stop).
// Runs from the 125 kHz sample clock; CLKS_PER_BIT=4 yields the 31.25 kbaud MIDI rate.
module midi_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_strobe,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 tx_d, busy_d;
    logic                 bit_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            tx        <= tx_d;
            busy      <= busy_d;
        end
    end

    // tx and busy are computed one edge ahead so both leave the block registered.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        tx_d      = tx;
        busy_d    = busy;
        bit_done  = (clk_cnt_q == CNT_LAST);

        if (state_q != S_IDLE) begin
            clk_cnt_d = bit_done ? '0 : clk_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (tx_strobe) begin
                    state_d   = S_START;
                    shreg_d   = data;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // Next bit is shreg_q[1], i.e. bit 0 after the shift.
                        shreg_d   = shreg_q >> 1;
                        tx_d      = shreg_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_midi_uart_tx.sv
// Bench for midi_uart_tx: table of known frames, hand-written reset/overlap sequences,
// and randomized strobes checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_midi_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_strobe = 1'b0;
    logic [7:0] data = 8'h00;
    logic       tx;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    midi_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_strobe (tx_strobe),
        .data      (data),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is {stop, byte, start}; each bit lasts CPB cycles.
    logic       m_active;
    int         m_k;
    logic [7:0] m_byte;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_byte   <= 8'h00;
        end else if (m_active) begin
            if (m_k == FRAME - 1) m_active <= 1'b0;
            else                  m_k      <= m_k + 1;
        end else if (tx_strobe) begin
            m_active <= 1'b1;
            m_k      <= 0;
            m_byte   <= data;
        end
    end

    function automatic logic model_tx();
        logic [9:0] fr;
        fr = {1'b1, m_byte, 1'b0};
        return m_active ? fr[m_k / CPB] : 1'b1;
    endfunction

    typedef struct {
        logic [7:0] d;
        logic [9:0] pat;     // pat[i] = line level during bit slot i (0 = start, 9 = stop)
        bit         hammer;  // strobe with data 0x00 on every cycle of the frame
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: tx/busy got %b required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mchk(input string name);
        chk(name, {tx, busy}, {model_tx(), m_active});
    endtask

    initial begin
        vecs[0] = '{d: 8'h80, pat: 10'b1100000000, hammer: 1'b0};
        vecs[1] = '{d: 8'h55, pat: 10'b1010101010, hammer: 1'b0};
        vecs[2] = '{d: 8'hFF, pat: 10'b1111111110, hammer: 1'b1};
        vecs[3] = '{d: 8'h12, pat: 10'b1000100100, hammer: 1'b0};
        vecs[4] = '{d: 8'h34, pat: 10'b1001101000, hammer: 1'b0};
        vecs[5] = '{d: 8'h00, pat: 10'b1000000000, hammer: 1'b0};

        // Reset held low while clock and strobe toggle.
        #1 rst = 1'b0;
        #1 chk("reset_async", {tx, busy}, 2'b10);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tx_strobe = 1'b1;
            data      = 8'($urandom);
            tick();
            chk("reset_hold", {tx, busy}, 2'b10);
        end
        @(negedge clk);
        tx_strobe = 1'b0;
        rst       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_reset_idle", {tx, busy}, 2'b10);
        end

        // Table frames; entries 3 and 4 run back-to-back with one idle cycle between.
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            tx_strobe = 1'b1;
            data      = vecs[v].d;
            for (int k = 0; k <= FRAME; k++) begin
                tick();
                if (k < FRAME)
                    chk($sformatf("vec%0d_k%0d", v, k), {tx, busy}, {vecs[v].pat[k / CPB], 1'b1});
                else
                    chk($sformatf("vec%0d_end", v), {tx, busy}, 2'b10);
                if (k == FRAME) begin
                    tx_strobe = 1'b0;
                    data      = 8'($urandom);
                end else if (vecs[v].hammer) begin
                    tx_strobe = 1'b1;
                    data      = 8'h00;
                end else begin
                    tx_strobe = ($urandom_range(0, 3) == 0);
                    data      = 8'($urandom);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_after_table", {tx, busy}, 2'b10);
        end

        // Reset during data bit 3 of 0xA5.
        @(negedge clk);
        tx_strobe = 1'b1;
        data      = 8'hA5;
        tick();
        tx_strobe = 1'b0;
        for (int k = 1; k <= 4 * CPB; k++) tick();
        chk("a5_bit3_before_reset", {tx, busy}, 2'b01);
        #2 rst = 1'b0;
        #1 chk("midframe_reset_immediate", {tx, busy}, 2'b10);
        tick();
        chk("midframe_reset_hold", {tx, busy}, 2'b10);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            data = 8'($urandom);
            chk("no_resume_after_reset", {tx, busy}, 2'b10);
        end

        // Randomized strobes, data churn and occasional async reset pulses.
        for (int c = 0; c < 1500; c++) begin
            tick();
            mchk("random_model");
            tx_strobe = ($urandom_range(0, 4) == 0);
            data      = 8'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
                #1 mchk("random_reset");
                #1 rst = 1'b1;
            end
        end
        tx_strobe = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
